neuron: RTL and testbench

NEURON -- requirements
Module: neuron

---
 rtl/neuron.sv | 138 +++++++++++++
 tb/tb_neuron.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/neuron.sv
// Spiking neuron: bias/membrane registers, a signed coupling-weight row, spike integration and firing.
// Define NEURON_VMEM_SAT_EN to saturate membrane accumulation instead of wrapping.
module neuron #(
    parameter int MU_DATA_WIDTH    = 16,
    parameter int VMEM_DATA_WIDTH  = 16,
    parameter int Q_ADDR_WIDTH     = 10,
    parameter int Q_DATA_WIDTH     = 2,
    parameter int SPIKE_ADDR_WIDTH = 10,
    parameter int SPIKE_DATA_WIDTH = SPIKE_ADDR_WIDTH + 2
) (
    input  logic                        clk,
    input  logic                        reset_l,
    input  logic                        en_neuron,
    input  logic                        en_spike,
    input  logic                        wrQ,
    input  logic                        wrVmem,
    input  logic                        wrNeuronI,
    input  logic                        wrMu,
    input  logic [SPIKE_ADDR_WIDTH-1:0] neuronI_in,
    input  logic [VMEM_DATA_WIDTH-1:0]  Vmem_in,
    input  logic [Q_DATA_WIDTH-1:0]     Q_in,
    input  logic [MU_DATA_WIDTH-1:0]    mu_in,
    input  logic [SPIKE_DATA_WIDTH-1:0] spike_in,
    input  logic                        networkDone,
    output logic [MU_DATA_WIDTH-1:0]    mu_out,
    output logic [SPIKE_DATA_WIDTH-1:0] spike_out,
    output logic                        neuronWrDone
);
    localparam int Q_DEPTH = 1 << Q_ADDR_WIDTH;
    localparam int VW      = VMEM_DATA_WIDTH;
    localparam int SUM_W   = ((VMEM_DATA_WIDTH > MU_DATA_WIDTH) ? VMEM_DATA_WIDTH : MU_DATA_WIDTH) + 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WRQ       = 3'd1;
    localparam logic [2:0] WRVMEM    = 3'd2;
    localparam logic [2:0] WRNEURONI = 3'd3;
    localparam logic [2:0] WRMU      = 3'd4;
    localparam logic [2:0] RUN       = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;

    logic signed [VW-1:0]            VmemQ;
    logic [SPIKE_ADDR_WIDTH-1:0]     neuronIQ;
    logic signed [MU_DATA_WIDTH-1:0] muQ;
    logic                            sQ;
    logic [Q_ADDR_WIDTH-1:0]         qPtr;
    logic signed [Q_DATA_WIDTH-1:0]  Q [Q_DEPTH];
    logic [2:0]                      state;
    logic [SPIKE_DATA_WIDTH-1:0]     r_spikeOut;

    logic [2:0]                      w_nextState;
    logic                            w_spkValid;
    logic                            w_spkPol;
    logic [SPIKE_ADDR_WIDTH-1:0]     w_spkIdx;
    logic                            w_spkHit;
    logic signed [Q_DATA_WIDTH-1:0]  w_qSel;
    logic signed [VW:0]              w_qExt;
    logic signed [VW:0]              w_vExt;
    logic signed [VW:0]              w_acc;
    logic                            w_ovf;
    logic signed [VW-1:0]            w_vmemNext;
    logic signed [SUM_W-1:0]         w_sum;
    logic                            w_fire;

    assign w_spkValid = spike_in[SPIKE_DATA_WIDTH-1];
    assign w_spkPol   = spike_in[SPIKE_DATA_WIDTH-2];
    assign w_spkIdx   = spike_in[SPIKE_ADDR_WIDTH-1:0];
    assign w_spkHit   = w_spkValid && (w_spkIdx != neuronIQ);
    assign w_qSel     = Q[w_spkIdx[Q_ADDR_WIDTH-1:0]];

    // One guard bit above the membrane width exposes overflow for either policy.
    assign w_qExt = {{(VW + 1 - Q_DATA_WIDTH){w_qSel[Q_DATA_WIDTH-1]}}, w_qSel};
    assign w_vExt = {VmemQ[VW-1], VmemQ};
    assign w_acc  = w_spkPol ? (w_vExt + w_qExt) : (w_vExt - w_qExt);
    assign w_ovf  = w_acc[VW] ^ w_acc[VW-1];

`ifdef NEURON_VMEM_SAT_EN
    assign w_vmemNext = !w_ovf ? w_acc[VW-1:0] :
                        (w_acc[VW] ? {1'b1, {(VW-1){1'b0}}} : {1'b0, {(VW-1){1'b1}}});
`else
    assign w_vmemNext = w_acc[VW-1:0];
`endif

    // Firing uses the registered membrane value, so a spike shows up one cycle later.
    assign w_sum  = {{(SUM_W - VW){VmemQ[VW-1]}}, VmemQ}
                  + {{(SUM_W - MU_DATA_WIDTH){muQ[MU_DATA_WIDTH-1]}}, muQ};
    assign w_fire = !w_sum[SUM_W-1] && (|w_sum);

    always_comb begin
        w_nextState = IDLE;
        if (!en_neuron)      w_nextState = IDLE;
        else if (networkDone) w_nextState = DONE;
        else if (wrQ)        w_nextState = WRQ;
        else if (wrVmem)     w_nextState = WRVMEM;
        else if (wrNeuronI)  w_nextState = WRNEURONI;
        else if (wrMu)       w_nextState = WRMU;
        else if (en_spike)   w_nextState = RUN;
    end

    always_ff @(posedge clk) begin
        if (reset_l) begin
            VmemQ      <= '0;
            neuronIQ   <= '0;
            muQ        <= '0;
            sQ         <= 1'b0;
            qPtr       <= '0;
            r_spikeOut <= '0;
            state      <= IDLE;
        end else begin
            state      <= w_nextState;
            r_spikeOut <= '0;
            case (w_nextState)
                WRQ:       qPtr     <= qPtr + 1'b1;
                WRVMEM:    VmemQ    <= Vmem_in;
                WRNEURONI: neuronIQ <= neuronI_in;
                WRMU:      muQ      <= mu_in;
                RUN: begin
                    if (w_spkHit) VmemQ <= w_vmemNext;
                    if (w_fire != sQ) begin
                        sQ         <= w_fire;
                        r_spikeOut <= {1'b1, w_fire, neuronIQ};
                    end
                end
                default: ;
            endcase
        end
    end

    // Weight row is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!reset_l && (w_nextState == WRQ)) Q[qPtr] <= Q_in;
    end

    // qPtr only returns to zero in WRQ after the final row entry was written.
    assign neuronWrDone = (state == WRQ) && (qPtr == '0);
    assign mu_out       = muQ;
    assign spike_out    = r_spikeOut;

endmodule

// File: tb/tb_neuron.sv
// Directed bench for neuron: register writes, Q row load, spike integration, firing and freeze.
module tb_neuron;
    logic        clk = 1'b0;
    logic        reset_l, en_neuron, en_spike;
    logic        wrQ, wrVmem, wrNeuronI, wrMu, networkDone;
    logic [9:0]  neuronI_in;
    logic [15:0] Vmem_in, mu_in, mu_out;
    logic [1:0]  Q_in;
    logic [11:0] spike_in, spike_out;
    logic        neuronWrDone;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    neuron dut (
        .clk(clk), .reset_l(reset_l), .en_neuron(en_neuron), .en_spike(en_spike),
        .wrQ(wrQ), .wrVmem(wrVmem), .wrNeuronI(wrNeuronI), .wrMu(wrMu),
        .neuronI_in(neuronI_in), .Vmem_in(Vmem_in), .Q_in(Q_in), .mu_in(mu_in),
        .spike_in(spike_in), .networkDone(networkDone),
        .mu_out(mu_out), .spike_out(spike_out), .neuronWrDone(neuronWrDone)
    );

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_vmem(input logic [15:0] v);
        wrVmem = 1'b1; Vmem_in = v; step(); wrVmem = 1'b0;
    endtask

    task automatic spike(input logic [11:0] s);
        spike_in = s; step(); spike_in = '0;
    endtask

    int early;

    initial begin
        reset_l = 1'b1; en_neuron = 1'b1; en_spike = 1'b0;
        wrQ = 0; wrVmem = 0; wrNeuronI = 0; wrMu = 0; networkDone = 0;
        neuronI_in = '0; Vmem_in = '0; Q_in = '0; mu_in = '0; spike_in = '0;
        step();
        reset_l = 1'b0;
        chk("rst_spike", spike_out, 16'h0);
        chk("rst_done", neuronWrDone, 16'h0);
        chk("rst_mu", mu_out, 16'h0);
        chk("rst_vmem", dut.VmemQ, 16'h0);
        step();
        chk("idle_spike", spike_out, 16'h0);

        wr_vmem(16'h1234);
        chk("wr_vmem", dut.VmemQ, 16'h1234);
        wrNeuronI = 1; neuronI_in = 10'h03A; step(); wrNeuronI = 0;
        chk("wr_nidx", dut.neuronIQ, 16'h003A);
        wrMu = 1; mu_in = 16'h5678; step(); wrMu = 0;
        chk("wr_mu", mu_out, 16'h5678);

        // wrVmem outranks wrMu in the same cycle
        wrVmem = 1; Vmem_in = 16'h0000; wrMu = 1; mu_in = 16'h1111; step();
        wrVmem = 0; wrMu = 0;
        chk("prio_vmem", dut.VmemQ, 16'h0000);
        chk("prio_mu", mu_out, 16'h5678);

        // Load row: Q[5]=+1, Q[7]=-1, Q[0x3A]=+1, rest 0
        early = 0;
        for (int i = 0; i < 1024; i++) begin
            wrQ = 1;
            Q_in = (i == 5 || i == 58) ? 2'b01 : (i == 7) ? 2'b11 : 2'b00;
            step();
            if (i < 1023 && neuronWrDone) early++;
        end
        wrQ = 0;
        chk("wrdone_early", early[15:0], 16'h0);
        chk("wrdone_pulse", neuronWrDone, 16'h1);
        chk("qptr_wrap", dut.qPtr, 16'h0);
        wrMu = 1; mu_in = 16'h0000; step(); wrMu = 0;
        chk("wrdone_clear", neuronWrDone, 16'h0);

        // Integration and firing, Vmem=0, mu=0, sQ=0
        en_spike = 1;
        spike(12'hC05);
        chk("int_plus", dut.VmemQ, 16'h0001);
        chk("no_fire_yet", spike_out, 16'h0);
        step();
        chk("fire_up", spike_out, 16'hC3A);
        step();
        chk("fire_once", spike_out, 16'h0);
        spike(12'h805);
        chk("int_minus", dut.VmemQ, 16'h0000);
        step();
        chk("fire_down", spike_out, 16'h83A);
        spike(12'hC07);
        chk("int_negq", dut.VmemQ, 16'hFFFF);
        spike(12'h807);
        chk("sub_negq", dut.VmemQ, 16'h0000);

        spike(12'hC3A);
        chk("self_idx", dut.VmemQ, 16'h0000);
        spike(12'h405);
        chk("invalid", dut.VmemQ, 16'h0000);

        // Freeze: spikes and strobes ignored, no output
        networkDone = 1;
        spike(12'hC05);
        chk("done_vmem", dut.VmemQ, 16'h0000);
        chk("done_spike", spike_out, 16'h0);
        wr_vmem(16'h00AA);
        chk("done_wr", dut.VmemQ, 16'h0000);
        networkDone = 0;

        // Write beats a simultaneous spike
        wrVmem = 1; Vmem_in = 16'h0010; spike_in = 12'hC05; step();
        wrVmem = 0; spike_in = '0;
        chk("wr_vs_spike", dut.VmemQ, 16'h0010);

        wr_vmem(16'h7FFF);
        spike(12'hC05);
`ifdef NEURON_VMEM_SAT_EN
        chk("pos_edge", dut.VmemQ, 16'h7FFF);
`else
        chk("pos_edge", dut.VmemQ, 16'h8000);
`endif
        wr_vmem(16'h8000);
        spike(12'h805);
`ifdef NEURON_VMEM_SAT_EN
        chk("neg_edge", dut.VmemQ, 16'h8000);
`else
        chk("neg_edge", dut.VmemQ, 16'h7FFF);
`endif

        // Disabled neuron holds and stays quiet
        wr_vmem(16'h0002);
        en_neuron = 0;
        spike(12'hC05);
        chk("dis_vmem", dut.VmemQ, 16'h0002);
        chk("dis_spike", spike_out, 16'h0);
        en_neuron = 1;

        // Reset mid-run clears registers but keeps the weight row
        reset_l = 1; spike_in = 12'hC05; step(); reset_l = 0; spike_in = '0;
        chk("rst2_vmem", dut.VmemQ, 16'h0);
        chk("rst2_nidx", dut.neuronIQ, 16'h0);
        chk("rst2_q5", dut.Q[5], 16'h1);
        spike(12'hC05);
        chk("q_kept", dut.VmemQ, 16'h0001);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
